// File: rtl/sum_pkg.sv
// Shared defaults, width derivation and output saturation for the packet sum path.
package sum_pkg;

  localparam int N_DEF         = 32;
  localparam int IN_W_DEF      = 16;
  localparam int IN_FRAC_DEF   = 12;
  localparam int OUT_W_DEF     = 32;
  localparam int OUT_FRAC_DEF  = 26;
  localparam int MAX_BEATS_DEF = 16;

  // Wide enough for any accumulator width this block is configured with.
  localparam int WIDE_W = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic [WIDE_W-1:0] value;
    logic              sat;
  } sat_t;

  function automatic int acc_width(input int in_w, input int shift,
                                   input int log2n, input int max_beats);
    return in_w + shift + log2n + $clog2(max_beats) + 1;
  endfunction

  function automatic sat_t sat_out(input wide_t value, input int out_w,
                                   input logic signed_mode);
    sat_t  res;
    wide_t hi;
    wide_t lo;
    if (signed_mode) begin
      hi = (wide_t'(1'b1) <<< (out_w - 1)) - wide_t'(1'b1);
      lo = -(wide_t'(1'b1) <<< (out_w - 1));
    end else begin
      hi = (wide_t'(1'b1) <<< out_w) - wide_t'(1'b1);
      lo = '0;
    end
    if (value > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (value < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end else begin
      res.value = value;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_adder_tree.sv
// Pipelined pairwise adder tree: log2(N) registered stages, one bit of growth per
// stage, with valid/last travelling alongside the partial sums.
module sum_adder_tree
  import sum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = IN_W_DEF + OUT_FRAC_DEF - IN_FRAC_DEF,
  localparam int LOG2N = $clog2(N),
  localparam int OW = W + LOG2N
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic [N-1:0][W-1:0]  i_data,
  output logic                 o_valid,
  output logic                 o_last,
  output logic signed [OW-1:0] o_sum
);

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int IW = W + s;
    localparam int NO = N >> (s + 1);

    logic signed [IW-1:0] in_s [2*NO];
    logic                 in_v_s;
    logic                 in_l_s;
    logic signed [IW:0]   sum_r [NO];
    logic                 v_r;
    logic                 l_r;

    if (s == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_lane
        assign in_s[k] = i_data[k];
      end
      assign in_v_s = i_valid;
      assign in_l_s = i_last;
    end else begin : g_chain
      for (genvar k = 0; k < 2*NO; k++) begin : g_node
        assign in_s[k] = g_stage[s-1].sum_r[k];
      end
      assign in_v_s = g_stage[s-1].v_r;
      assign in_l_s = g_stage[s-1].l_r;
    end

    // Pairwise sign-extended add into this stage's registers.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int k = 0; k < NO; k++) sum_r[k] <= '0;
        v_r <= 1'b0;
        l_r <= 1'b0;
      end else if (i_en) begin
        for (int k = 0; k < NO; k++) begin
          sum_r[k] <= {in_s[2*k][IW-1], in_s[2*k]} + {in_s[2*k+1][IW-1], in_s[2*k+1]};
        end
        v_r <= in_v_s;
        l_r <= in_l_s;
      end
    end
  end

  assign o_sum   = g_stage[LOG2N-1].sum_r[0];
  assign o_valid = g_stage[LOG2N-1].v_r;
  assign o_last  = g_stage[LOG2N-1].l_r;

endmodule

// File: rtl/sum_accumulator.sv
// Multi-beat packet summer: aligns lanes to the output format, reduces them through
// the adder tree, accumulates beats until last (or MAX_BEATS) and saturates.
module sum_accumulator
  import sum_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int IN_W        = IN_W_DEF,
  parameter int IN_FRAC     = IN_FRAC_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int OUT_FRAC    = OUT_FRAC_DEF,
  parameter bit SIGNED_MODE = 1'b0,
  parameter int MAX_BEATS   = MAX_BEATS_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N-1:0][IN_W-1:0] i_data,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [OUT_W-1:0]       o_sum,
  output logic                   o_sat,
  output logic                   o_overrun
);

  localparam int LOG2N     = $clog2(N);
  localparam int SHIFT     = OUT_FRAC - IN_FRAC;
  localparam int TREE_IN_W = IN_W + SHIFT;
  localparam int TREE_W    = TREE_IN_W + LOG2N;
  localparam int ACC_W     = acc_width(IN_W, SHIFT, LOG2N, MAX_BEATS);
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic                           en_s;
  logic [N-1:0][TREE_IN_W-1:0]    lanes_s;
  logic                           tree_vld_s;
  logic                           tree_last_s;
  logic signed [TREE_W-1:0]       tree_sum_s;
  logic signed [ACC_W-1:0]        acc_r;
  logic signed [ACC_W-1:0]        sum_s;
  logic [CNT_W-1:0]               cnt_r;
  logic                           close_s;
  sat_t                           sat_s;
  logic                           unused_s;

  // The whole pipeline freezes only while a result is waiting on downstream.
  assign en_s    = !(o_valid && !i_ready);
  assign o_ready = en_s;

  // Align each lane to the output fraction; unsigned mode drops negative lanes.
  always_comb begin
    lanes_s = '0;
    for (int k = 0; k < N; k++) begin
      if ((SIGNED_MODE == 1'b0) && i_data[k][IN_W-1]) begin
        lanes_s[k] = '0;
      end else begin
        lanes_s[k] = TREE_IN_W'($signed(i_data[k])) << SHIFT;
      end
    end
  end

  sum_adder_tree #(
    .N (N),
    .W (TREE_IN_W)
  ) u_tree (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (en_s),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_data  (lanes_s),
    .o_valid (tree_vld_s),
    .o_last  (tree_last_s),
    .o_sum   (tree_sum_s)
  );

  assign close_s = tree_last_s || (cnt_r == CNT_W'(MAX_BEATS - 1));

  // Running packet total including the beat now leaving the tree, and its saturated form.
  always_comb begin
    sum_s = acc_r + ACC_W'(tree_sum_s);
    sat_s = sat_out(wide_t'(sum_s), OUT_W, SIGNED_MODE);
  end

  assign unused_s = ^sat_s.value[WIDE_W-1:OUT_W];

  // Accumulate beats; on packet close publish the saturated sum and restart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      o_valid   <= 1'b0;
      o_sum     <= '0;
      o_sat     <= 1'b0;
      o_overrun <= 1'b0;
    end else if (en_s) begin
      o_valid <= 1'b0;
      if (tree_vld_s) begin
        if (close_s) begin
          o_sum     <= sat_s.value[OUT_W-1:0];
          o_sat     <= sat_s.sat;
          o_overrun <= !tree_last_s;
          o_valid   <= 1'b1;
          acc_r     <= '0;
          cnt_r     <= '0;
        end else begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + CNT_W'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: default, signed-mode and MAX_BEATS=4 instances share one stimulus stream.
module tb_sum_accumulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              i_last;
  logic              i_ready;
  logic [31:0][15:0] data;

  logic        vld [3];
  logic        rdy [3];
  logic        sat [3];
  logic        ovr [3];
  logic [31:0] sum [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_accumulator u_def (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy[0]), .i_data(data),
    .i_last(i_last), .o_valid(vld[0]), .i_ready(i_ready), .o_sum(sum[0]),
    .o_sat(sat[0]), .o_overrun(ovr[0]));

  sum_accumulator #(.SIGNED_MODE(1'b1)) u_sgn (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy[1]), .i_data(data),
    .i_last(i_last), .o_valid(vld[1]), .i_ready(i_ready), .o_sum(sum[1]),
    .o_sat(sat[1]), .o_overrun(ovr[1]));

  sum_accumulator #(.MAX_BEATS(4)) u_ovr (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy[2]), .i_data(data),
    .i_last(i_last), .o_valid(vld[2]), .i_ready(i_ready), .o_sum(sum[2]),
    .o_sat(sat[2]), .o_overrun(ovr[2]));

  typedef struct {
    logic [15:0] l0;
    logic [15:0] rest;
    int          beats;
    logic [31:0] exp_u;
    logic        sat_u;
    logic [31:0] exp_s;
    logic        sat_s;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send(input logic [15:0] l0, input logic [15:0] rest, input logic last);
    int n;
    for (int k = 0; k < 32; k++) data[k] = rest;
    data[0] = l0;
    i_valid = 1'b1;
    i_last  = last;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[0]) begin
      total++;
      bad++;
      $display("FAIL send_timeout: o_ready stuck low");
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Count edges from the accepting edge (=1) until the chosen instance shows o_valid.
  task automatic wait_valid(input int idx, output int cyc);
    cyc = 1;
    while (!vld[idx] && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!vld[idx]) begin
      total++;
      bad++;
      $display("FAIL wait_valid_timeout: dut %0d never raised o_valid", idx);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] q[$];

    vecs[0] = '{16'h1000, 16'h1000, 1, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1};
    vecs[1] = '{16'h1000, 16'h1000, 2, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{16'h0800, 16'h0000, 1, 32'h0200_0000, 1'b0, 32'h0200_0000, 1'b0};
    vecs[3] = '{16'hF000, 16'hF000, 1, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b0};
    vecs[4] = '{16'hF000, 16'hF000, 2, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b1};
    vecs[5] = '{16'h1000, 16'hF000, 1, 32'h0400_0000, 1'b0, 32'h8800_0000, 1'b0};

    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(vld[0]), 32'h0);
    check("rst_sum", sum[0], 32'h0);
    check("rst_sat", 32'(sat[0]), 32'h0);
    check("rst_overrun", 32'(ovr[0]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < vecs[i].beats; b++) send(vecs[i].l0, vecs[i].rest, b == vecs[i].beats - 1);
      wait_valid(0, lat);
      if (i == 0) check("latency", 32'(lat), 32'd6);
      check($sformatf("v%0d_sum_u", i), sum[0], vecs[i].exp_u);
      check($sformatf("v%0d_sat_u", i), 32'(sat[0]), 32'(vecs[i].sat_u));
      check($sformatf("v%0d_ovr_u", i), 32'(ovr[0]), 32'h0);
      check($sformatf("v%0d_vld_s", i), 32'(vld[1]), 32'h1);
      check($sformatf("v%0d_sum_s", i), sum[1], vecs[i].exp_s);
      check($sformatf("v%0d_sat_s", i), 32'(sat[1]), 32'(vecs[i].sat_s));
      check($sformatf("v%0d_sum_m4", i), sum[2], vecs[i].exp_u);
      @(posedge clk); #1;
      check($sformatf("v%0d_vld_drop", i), 32'(vld[0]), 32'h0);
    end

    // Backpressure: three packets queued behind a stalled output.
    i_ready = 1'b0;
    send(16'h1000, 16'h0000, 1'b1);
    send(16'h0800, 16'h0000, 1'b1);
    send(16'h0400, 16'h0000, 1'b1);
    wait_valid(0, lat);
    for (int c = 0; c < 5; c++) begin
      check("stall_ready", 32'(rdy[0]), 32'h0);
      check("stall_valid", 32'(vld[0]), 32'h1);
      check("stall_sum", sum[0], 32'h0400_0000);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (vld[0]) q.push_back(sum[0]);
      @(posedge clk); #1;
    end
    check("stream_count", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      check("stream_0", q[0], 32'h0400_0000);
      check("stream_1", q[1], 32'h0200_0000);
      check("stream_2", q[2], 32'h0100_0000);
    end

    // Force-close at MAX_BEATS=4 without last; the 5th beat opens a new packet.
    for (int b = 0; b < 4; b++) send(16'h1000, 16'h0000, 1'b0);
    wait_valid(2, lat);
    check("ovr_sum", sum[2], 32'h1000_0000);
    check("ovr_flag", 32'(ovr[2]), 32'h1);
    check("ovr_sat", 32'(sat[2]), 32'h0);
    send(16'h1000, 16'h0000, 1'b1);
    wait_valid(2, lat);
    check("ovr_next_sum", sum[2], 32'h0400_0000);
    check("ovr_next_flag", 32'(ovr[2]), 32'h0);
    check("long_pkt_sum_u", sum[0], 32'h1400_0000);
    @(posedge clk); #1;

    // Reset with a partial sum already in the accumulator.
    send(16'h1000, 16'h0000, 1'b0);
    send(16'h1000, 16'h0000, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(vld[0]), 32'h0);
    check("mid_rst_sum", sum[0], 32'h0);
    check("mid_rst_sat", 32'(sat[0]), 32'h0);
    check("mid_rst_ovr", 32'(ovr[2]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(vld[0]), 32'h0);
    check("post_rst_sum", sum[0], 32'h0);
    send(16'h1000, 16'h0000, 1'b1);
    wait_valid(0, lat);
    check("post_rst_pkt", sum[0], 32'h0400_0000);
    check("post_rst_ovr", 32'(ovr[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Parametrised successor to the single-beat 32-lane sum finder used for the softmax denominator.
- Reduces N fixed-point lanes per beat through a registered adder tree, then accumulates beats until i_last to sum vectors longer than N.
- Converts Q(IN_W-IN_FRAC).IN_FRAC inputs to the Q(OUT_W-OUT_FRAC).OUT_FRAC output format and saturates the result.
- Selectable unsigned (clamp negatives) or signed mode; valid/ready backpressure on both sides.

Parameters:
- N, 32: lanes per beat; power of 2, >=2.
- IN_W, 16: input lane width (signed).
- IN_FRAC, 12: input fraction bits.
- OUT_W, 32: output width.
- OUT_FRAC, 26: output fraction bits; OUT_FRAC >= IN_FRAC.
- SIGNED_MODE, 0: 0 = negative lanes clamped to 0, unsigned output; 1 = two's complement signed output.
- MAX_BEATS, 16: maximum beats per packet, >=1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_data  in  N x IN_W  signed lanes.
- i_last  in  1  final beat of packet.
- o_valid  out  1  packet sum valid.
- i_ready  in  1  downstream accepts o_sum.
- o_sum  out  OUT_W  packet sum (unsigned or signed per SIGNED_MODE).
- o_sat  out  1  o_sum was saturated.
- o_overrun  out  1  packet force-closed at MAX_BEATS without i_last.

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_valid=0, o_sum=0, o_sat=0, o_overrun=0. Reset also clears all tree stages, valid/last sidebands, the accumulator and the beat counter. A reset mid-packet discards the partial sum.
- Handshake:
  - Beat accepted when i_valid && o_ready.
  - Global enable en = !(o_valid && !i_ready); o_ready = en.
  - All pipeline registers advance only when en=1.
  - o_valid, o_sum, o_sat and o_overrun hold stable while o_valid=1 and i_ready=0.
- Stage 0 (combinational):
  - Each lane is sign-extended and shifted left by (OUT_FRAC-IN_FRAC).
  - SIGNED_MODE=0: negative lanes become 0.
- Tree:
  - log2(N) registered pairwise-add stages.
  - Width grows 1 bit per stage, so no overflow inside the tree.
  - Valid and last travel alongside the data.
- Accumulator stage (1 register):
  - acc width ACC_W = IN_W + (OUT_FRAC-IN_FRAC) + log2(N) + clog2(MAX_BEATS) + 1. The accumulator cannot overflow within MAX_BEATS beats.
  - On a valid tree output: if the beat is not last, acc <= acc + tree.
  - If the beat is last, or beat_cnt == MAX_BEATS-1:
    - o_sum <= sat(acc + tree); o_valid <= 1.
    - acc <= 0; beat_cnt <= 0.
    - o_overrun <= !last.
  - Back-to-back packets need no idle cycle.
- Saturation:
  - SIGNED_MODE=0: clamp to [0, 2^OUT_W-1].
  - SIGNED_MODE=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_sat=1 when clamping occurred.
- o_valid drops on the cycle after acceptance unless a new result is produced that same cycle.
- Latency: o_valid asserts log2(N)+1 cycles after the last beat is accepted, with no stalls (6 cycles for N=32).
- Throughput: one beat per cycle while i_ready=1.
- beat_cnt counts beats arriving at the accumulator stage.

Decomposition:
- Package sum_pkg holds:
  - function sat_out(value, signed_mode) → OUT_W result plus sat flag;
  - localparams for LOG2N, SHIFT = OUT_FRAC-IN_FRAC, and ACC_W derivation.
- Sub-module sum_adder_tree: parametrised (N, width) pipelined tree with en, valid/last sideband and synchronous reset.
- sum_accumulator instantiates sum_adder_tree and adds stage 0, the accumulator, the beat counter and the output register.

Test Plan:
- Defaults, one beat, all lanes 0x1000 (1.0), i_last=1 → after 6 cycles o_valid=1, o_sum=0x8000_0000, o_sat=0, o_overrun=0.
- Two beats, all lanes 0x1000, last on beat 2 → o_sum=0xFFFF_FFFF, o_sat=1. Then a third single beat with lane0=0x0800 and others 0 → o_sum=0x0200_0000, o_sat=0, confirming the accumulator cleared.
- SIGNED_MODE=0, all lanes 0xF000 (-1.0), last → o_sum=0. SIGNED_MODE=1, same stimulus → o_sum=0x8000_0000, o_sat=0. SIGNED_MODE=1, two such beats → o_sum=0x8000_0000, o_sat=1.
- Three one-beat packets streamed with i_ready held low for 5 cycles after the first o_valid → o_ready=0 while stalled, o_sum constant. After release, three results appear in order with no loss or duplication.
- MAX_BEATS=4, five beats of lane0=0x1000, no i_last → after the 4th beat o_sum=0x1000_0000 with o_overrun=1. The 5th beat starts a new packet.
- Assert i_rst for one cycle midway through a 3-beat packet, then send a 1-beat packet with lane0=0x1000 → o_sum=0x0400_0000. All outputs are 0 during and immediately after reset.
